// File: rtl/gray_codec_pipe.sv
// Elastic binary/Gray converter: conversion happens at acceptance, then the beat
// travels through STAGES collapsible register slots. Decode beats feed an adjacency checker.
module gray_codec_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_adj_err,
  input  logic             chk_clr,
  output logic [CNT_W-1:0] err_cnt
);

  function automatic logic [WIDTH-1:0] gray_enc(input logic [WIDTH-1:0] d);
    return d ^ (d >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray_dec(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  data_p [STAGES];
  logic              mode_p [STAGES];
  logic              adj_p  [STAGES];

  logic [WIDTH-1:0]  prev;
  logic              prev_vld;
  logic              accept;
  logic              adj_in;
  logic [WIDTH-1:0]  conv_in;

  // A slot moves when any slot above it is empty or the output is draining.
  always_comb begin
    logic hole;
    hole = out_ready;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = vld_p[k] & hole;
      hole   = hole | ~vld_p[k];
    end
  end

  assign in_ready = ~vld_p[0] | adv[0];
  assign accept   = in_valid & in_ready;
  assign conv_in  = in_mode ? gray_dec(in_data) : gray_enc(in_data);
  // A same-edge clear wins over flagging the incoming beat.
  assign adj_in   = in_mode & prev_vld & ~chk_clr & ($countones(in_data ^ prev) != 1);

  // Input -> slot 0 -> ... -> slot STAGES-1 (output)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_p[k] <= '0;
        mode_p[k] <= 1'b0;
        adj_p[k]  <= 1'b0;
      end
    end else begin
      if (accept) begin
        vld_p[0]  <= 1'b1;
        data_p[0] <= conv_in;
        mode_p[0] <= in_mode;
        adj_p[0]  <= adj_in;
      end else if (adv[0]) begin
        vld_p[0] <= 1'b0;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k-1]) begin
          vld_p[k]  <= 1'b1;
          data_p[k] <= data_p[k-1];
          mode_p[k] <= mode_p[k-1];
          adj_p[k]  <= adj_p[k-1];
        end else if (adv[k]) begin
          vld_p[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      prev_vld <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (accept && in_mode) begin
        prev     <= in_data;
        prev_vld <= 1'b1;
      end else if (chk_clr) begin
        prev_vld <= 1'b0;
      end
      if (chk_clr)              err_cnt <= '0;
      else if (accept && adj_in) err_cnt <= sat_inc(err_cnt);
    end
  end

  assign out_valid   = vld_p[STAGES-1];
  assign out_data    = data_p[STAGES-1];
  assign out_mode    = mode_p[STAGES-1];
  assign out_adj_err = adj_p[STAGES-1];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Randomized and directed bench for gray_codec_pipe with a queue scoreboard;
// a second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_gray_codec_pipe;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_mode, out_ready, chk_clr;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, out_mode, out_adj_err;
  logic [W-1:0] out_data;
  logic [15:0]  err_cnt;
  logic         in_ready2, out_valid2, out_mode2, out_adj_err2;
  logic [W-1:0] out_data2;
  logic [1:0]   err_cnt2;

  gray_codec_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .out_adj_err(out_adj_err), .chk_clr(chk_clr), .err_cnt(err_cnt));

  gray_codec_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_mode(out_mode2),
    .out_adj_err(out_adj_err2), .chk_clr(chk_clr), .err_cnt(err_cnt2));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         m;
    logic         a;
    int           acc;
  } beat_t;

  beat_t        q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] m_prev = '0;
  logic         m_pv = 1'b0;
  int           m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] enc_ref(input logic [W-1:0] d);
    int v;
    v = int'(d);
    v = v ^ (v / 2);
    return v[W-1:0];
  endfunction

  // Decode by searching for the binary value whose Gray code matches.
  function automatic logic [W-1:0] dec_ref(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++)
      if (enc_ref(b[W-1:0]) == g) return b[W-1:0];
    return '0;
  endfunction

  function automatic int hamming(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    for (int i = 0; i < W; i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  // Reference checker and acceptance tracking; runs ahead of each active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      beat_t e;
      logic  dec_acc;
      chk("err_cnt", err_cnt, m_cnt);
      chk("err_cnt_sat", err_cnt2, (m_cnt > 3) ? 3 : m_cnt);
      dec_acc = 1'b0;
      if (in_valid && in_ready) begin
        e.d   = in_mode ? dec_ref(in_data) : enc_ref(in_data);
        e.m   = in_mode;
        e.a   = in_mode && m_pv && !chk_clr && (hamming(in_data, m_prev) != 1);
        e.acc = cyc + 1;
        q.push_back(e);
        if (in_mode) begin
          m_prev  = in_data;
          m_pv    = 1'b1;
          dec_acc = 1'b1;
        end
        if (!chk_clr && e.a) m_cnt++;
      end
      if (chk_clr) begin
        m_cnt = 0;
        if (!dec_acc) m_pv = 1'b0;
      end
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      logic  exp_v;
      beat_t e;
      exp_v = (q.size() > 0) && (cyc - q[0].acc >= S - 1);
      chk("out_valid", out_valid, exp_v);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra got beat %0h expected none", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_mode", out_mode, e.m);
          chk("out_adj_err", out_adj_err, e.a);
          chk("out_data_w2", out_data2, e.d);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic m,
                      input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy; chk_clr = clr;
    #1;
    if (rst_n) chk("in_ready", in_ready, ordy || (q.size() < S));
  endtask

  task automatic direct(input logic [W-1:0] d, input logic m, input logic [W-1:0] exp);
    step(1'b1, d, m, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("dir_valid", out_valid, 1);
    chk("dir_data", out_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] bp [4];
    int           idx;
    logic [W-1:0] d;
    logic         m;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    out_ready = 1'b0; chk_clr = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    direct(8'h05, 1'b0, 8'h07);
    direct(8'hAA, 1'b0, 8'hFF);
    direct(8'h07, 1'b1, 8'h05);
    direct(8'hFF, 1'b1, 8'hAA);
    direct(8'h80, 1'b1, 8'hFF);

    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    foreach (bp[i]) bp[i] = '0;
    bp[0] = 8'h00; bp[1] = 8'h01; bp[2] = 8'h03; bp[3] = 8'h03;
    for (int i = 0; i < 4; i++) step(1'b1, bp[i], 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("adj_cnt2", err_cnt, 2);
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("adj_clr_cnt", err_cnt, 0);

    repeat (5) step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("sat_cnt16", err_cnt, 5);
    chk("sat_cnt2", err_cnt2, 3);

    bp[0] = 8'h12; bp[1] = 8'h34; bp[2] = 8'h56; bp[3] = 8'h78;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, bp[(idx < 4) ? idx : 3], i[0], 1'b0, 1'b0);
      if (in_ready && idx < 4) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 20 && idx < 4; i++) begin
      step(1'b1, bp[idx], 1'b0, 1'b1, 1'b0);
      if (in_ready) idx++;
    end
    chk("bp_all_sent", idx, 4);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("bp_drained", q.size(), 0);

    step(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    q.delete();
    m_prev = '0; m_pv = 1'b0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      m = 1'(($urandom % 3) != 0);
      d = 8'($urandom);
      if (m && ($urandom % 2 == 0)) d = m_prev ^ (8'd1 << ($urandom % W));
      step(1'(($urandom % 4) != 0), d, m, 1'(($urandom % 4) != 0),
           1'(($urandom % 25) == 0));
    end
    repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("final_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
